ps2_key_tracker: RTL
====================

# ps2_key_tracker

Consumes scan-code bytes from `ps2_keyboard` through its `ready`/`nextdata_n` FIFO handshake and decodes set-2 make, break (F0) and extended (E0) sequences. It tracks the currently held key, counts key presses with optional typematic-repeat filtering, and drives four active-low hex seven-segment digits: two for the held code and two for the count. It replaces the ad-hoc controller logic in `top`, sitting between `ps2_keyboard` and the board display/LED pins.

## Interface
- `CNT_WIDTH`, default 8: press-counter width; must be ≥ 8. The counter wraps modulo 2^CNT_WIDTH.
- `REPEAT_FILTER`, default 1:
  - 1: a make of the already-held key (typematic repeat) is not counted.
  - 0: every make is counted.

- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ready` in 1: from `ps2_keyboard`; FIFO non-empty, and `data` is valid.
- `data` in 8: FIFO head byte.
- `overflow` in 1: from `ps2_keyboard` FIFO.
- `nextdata_n` out 1: active-low pop, registered.
- `key_code` out 8: code of the most recently pressed key.
- `key_ext` out 1: that key was E0-prefixed.
- `key_down` out 1: the key is currently held.
- `key_evt` out 1: one-cycle pulse per counted press.
- `press_cnt` out CNT_WIDTH: counted presses.
- `ovf_seen` out 1: sticky; set when `overflow`=1 is sampled.
- `seg0`, `seg1` out 8 each: low and high hex nibble of `key_code`.
- `seg4`, `seg5` out 8 each: low and high hex nibble of `press_cnt[7:0]`.

## Operation
- **Handshake FSM:**
  - **IDLE** (`nextdata_n`=1). When `ready`=1, the byte is consumed at that edge, `nextdata_n` is driven to 0, and the FSM moves to **POP**.
  - **POP** (`nextdata_n`=0 for exactly one cycle). The FSM returns unconditionally to IDLE.
  - `ready` is ignored in POP.
  - Maximum throughput is one byte per 2 cycles.
- **Pending flags** `brk_p` and `ext_p` are internal and are updated on each consumed byte:
  - **0xE0:** sets `ext_p`; no other effect.
  - **0xF0:** sets `brk_p`; no other effect.
  - **0x00 or 0xFF** (keyboard error/overrun): ignored; clears both flags.
  - **Other code c with `brk_p`=1:** if `key_down` && c==`key_code` && `ext_p`==`key_ext`, then `key_down`←0. Otherwise ignored. The codes and count are unchanged, and both flags are cleared.
  - **Other code c with `brk_p`=0, repeat case:** if `key_down` && c==`key_code` && `ext_p`==`key_ext`, it is a repeat. With REPEAT_FILTER=0: `press_cnt`+1 and `key_evt`. With REPEAT_FILTER=1: no change.
  - **Other code c with `brk_p`=0, new press:** `key_code`←c, `key_ext`←`ext_p`, `key_down`←1, `press_cnt`+1, `key_evt`=1.
  - Both flags are cleared after any code byte.
- **Multi-key behaviour:** a new make while another key is held replaces the tracked key (last-pressed wins). A later break of the old key is ignored.
- **Overflow:** `ovf_seen` is set whenever `overflow`=1 at a clock edge and is cleared only by `rst`.
- **Display encoding:** each digit is the bitwise inverse of the active-high pattern {a,b,c,d,e,f,g,dp}, with bit7=a and dp always off.
  - Examples: 0 → 8'b00000011, 1 → 8'b10011111, 5 → 8'b01001001.
  - Hex A–F use the standard forms: A, b, C, d, E, F.
  - Blank = 8'hFF.
- **Display contents:**
  - `seg0`/`seg1` show `key_code` while `key_down`=1 and are blank otherwise.
  - `seg4`/`seg5` always show `press_cnt[7:0]`.
  - Segment outputs are combinational from registered state.

## Timing
- **Reset values:** FSM=IDLE, `nextdata_n`=1, `key_code`=0, `key_ext`=0, `key_down`=0, `key_evt`=0, `press_cnt`=0, `ovf_seen`=0, flags=0. Therefore `seg0`/`seg1`=FF and `seg4`=`seg5`=8'b00000011.
- **Latency:** byte consumed at edge N, meaning `ready`=1 in IDLE during cycle N−1.
  - `key_*`, `press_cnt` and `key_evt` update at edge N.
  - `nextdata_n`=0 during cycle N..N+1.
  - `ready` is re-sampled at edge N+2.
- **`key_evt`:** high for exactly one cycle per counted press and never on a break.
- **Wrap:** `press_cnt`=all-ones followed by a counted press gives 0, with `key_evt` still pulsing.
- **Simultaneous events:** `overflow` and a byte consumed on the same edge are both handled independently.
- **Reset mid-sequence:** asserting `rst` between E0/F0 and the code byte discards the pending flags. Reset asserted during POP forces `nextdata_n`=1 immediately (asynchronously), so the FIFO is not popped on that edge.

## Test plan
- **Make/break of Q:** bytes 15, F0, 15 → during the hold, `key_code`=15, `seg0`=~'5', `seg1`=~'1', `press_cnt`=1 with one `key_evt`. After the break, `key_down`=0, `seg0`/`seg1`=FF, and `seg4`=~'1'.
- **Extended key:** bytes E0 75, then 75, then F0 75 → `key_ext`=1 with code 75, then a new press with `key_ext`=0 and `press_cnt`=2. The F0 75 releases it.
- **Repeat filtering:** bytes 1C 1C 1C F0 1C → `press_cnt`=1 with REPEAT_FILTER=1, and 3 (three `key_evt`) with REPEAT_FILTER=0.
- **Counter wrap:** 256 distinct make/break pairs with CNT_WIDTH=8 → `press_cnt`=0 and `seg4`=`seg5`=~'0'. Release of a non-held key (F0 23) leaves the state unchanged.
- **Handshake throughput:** `ready` held high across 3 queued bytes → exactly 3 single-cycle `nextdata_n` low pulses, separated by one high cycle. No pop occurs while `ready`=0.
- **Reset mid-sequence:** `rst` pulsed after F0 during POP → all outputs at reset values, `nextdata_n`=1 asynchronously. A following 15 byte is treated as a new make.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code tracker: pops bytes from the keyboard FIFO, decodes
// make/break/extended sequences, counts presses and drives hex digits.
module ps2_key_tracker #(
  parameter int CNT_WIDTH     = 8,
  parameter bit REPEAT_FILTER = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ready,
  input  logic [7:0]           data,
  input  logic                 overflow,
  output logic                 nextdata_n,
  output logic [7:0]           key_code,
  output logic                 key_ext,
  output logic                 key_down,
  output logic                 key_evt,
  output logic [CNT_WIDTH-1:0] press_cnt,
  output logic                 ovf_seen,
  output logic [7:0]           seg0,
  output logic [7:0]           seg1,
  output logic [7:0]           seg4,
  output logic [7:0]           seg5
);

  typedef enum logic {IDLE, POP} state_t;

  state_t state;
  logic   brk_p;
  logic   ext_p;
  logic   same_key;

  // Incoming code refers to the key we are already tracking
  assign same_key = key_down && (data == key_code) && (ext_p == key_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      nextdata_n <= 1'b1;
      key_code   <= 8'h00;
      key_ext    <= 1'b0;
      key_down   <= 1'b0;
      key_evt    <= 1'b0;
      press_cnt  <= '0;
      ovf_seen   <= 1'b0;
      brk_p      <= 1'b0;
      ext_p      <= 1'b0;
    end else begin
      key_evt <= 1'b0;
      if (overflow)
        ovf_seen <= 1'b1;
      case (state)
        IDLE: begin
          if (ready) begin
            nextdata_n <= 1'b0;
            state      <= POP;
            if (data == 8'hE0) begin
              ext_p <= 1'b1;
            end else if (data == 8'hF0) begin
              brk_p <= 1'b1;
            end else begin
              brk_p <= 1'b0;
              ext_p <= 1'b0;
              // 00/FF are keyboard error codes: only the flag clear applies
              if (data != 8'h00 && data != 8'hFF) begin
                if (brk_p) begin
                  if (same_key)
                    key_down <= 1'b0;
                end else if (same_key) begin
                  if (!REPEAT_FILTER) begin
                    press_cnt <= press_cnt + CNT_WIDTH'(1);
                    key_evt   <= 1'b1;
                  end
                end else begin
                  key_code  <= data;
                  key_ext   <= ext_p;
                  key_down  <= 1'b1;
                  press_cnt <= press_cnt + CNT_WIDTH'(1);
                  key_evt   <= 1'b1;
                end
              end
            end
          end
        end
        POP: begin
          nextdata_n <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          nextdata_n <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Active-low {a,b,c,d,e,f,g,dp} with dp always dark
  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return ~{s, 1'b0};
  endfunction

  assign seg0 = key_down ? hex7(key_code[3:0]) : 8'hFF;
  assign seg1 = key_down ? hex7(key_code[7:4]) : 8'hFF;
  assign seg4 = hex7(press_cnt[3:0]);
  assign seg5 = hex7(press_cnt[7:4]);

endmodule
